sram_access_arbiter: RTL and testbench



---
 rtl/sram_access_arbiter_if.sv | 37 +++
 rtl/sram_access_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_arbiter_if.sv
// sram_access_arbiter_if: requester handshakes and SRAM pin bundle for sram_access_arbiter.
// master: pixel fetch/store side plus SRAM read-data return; drives rd_req/rd_addr,
//         wr_req/wr_addr/wr_data and r_data, observes everything else.
// slave : the arbiter; drives rd_ack/rd_data, wr_ack, address/w_data, read/write_enable, busy.
interface sram_access_arbiter_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 24
);
    // read requester
    logic                 rd_req;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] rd_data;
    // write requester
    logic                 wr_req;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_ack;
    // SRAM pins
    logic [ADDR_BITS-1:0] address;
    logic [DATA_BITS-1:0] w_data;
    logic [DATA_BITS-1:0] r_data;
    logic                 read_enable;
    logic                 write_enable;
    // status
    logic                 busy;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, r_data,
        input  rd_ack, rd_data, wr_ack, address, w_data, read_enable, write_enable, busy
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, r_data,
        output rd_ack, rd_data, wr_ack, address, w_data, read_enable, write_enable, busy
    );
endinterface

// File: rtl/sram_access_arbiter.sv
// Purpose: shares one SRAM port between a pixel read requester and a pixel write requester,
//          holding address/enable for ACCESS_CYCLES and returning a one-cycle ack per access.
// Latency: grant in IDLE cycle k, enable high k+1..k+ACCESS_CYCLES, ack at k+ACCESS_CYCLES+1,
//          back in IDLE at k+ACCESS_CYCLES+2. Backpressure: requesters hold req/addr/data until ack.
// Ports: clk, n_rst (async active-low); bus (sram_access_arbiter_if.slave) carrying both
//        requester handshakes and the SRAM pins address/w_data/r_data/read_enable/write_enable, busy.
// Optional: SRAM_ARB_STATS_EN adds rd_count/wr_count, saturating 16-bit completed-access counters.
module sram_access_arbiter #(
    parameter int ADDR_BITS     = 16,
    parameter int DATA_BITS     = 24,
    parameter int ACCESS_CYCLES = 5,
    parameter int MAX_BURST     = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sram_access_arbiter_if.slave bus
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);
    localparam int CNT_W   = $clog2(ACCESS_CYCLES + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ACCESS_CYCLES);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic                 last_wr_q, last_wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DATA_BITS-1:0] rdata_q, rdata_d;
    logic                 re_q, re_d;
    logic                 we_q, we_d;
    logic                 rd_ack_q, rd_ack_d;
    logic                 wr_ack_q, wr_ack_d;

    logic any_req;
    logic other_req;
    logic burst_yield;
    logic grant_wr;

    // Arbitration decision, consumed only in IDLE. "other" is the side not served last.
    always_comb begin
        any_req     = bus.rd_req | bus.wr_req;
        other_req   = last_wr_q ? bus.rd_req : bus.wr_req;
        burst_yield = (burst_q == BURST_MAX) && other_req;
        if (burst_yield) begin
            grant_wr = ~last_wr_q;
        end else if (bus.rd_req && bus.wr_req) begin
            grant_wr = ~last_wr_q;
        end else begin
            grant_wr = bus.wr_req;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        last_wr_d = last_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        re_d      = 1'b0;
        we_d      = 1'b0;
        rd_ack_d  = 1'b0;
        wr_ack_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d   = grant_wr ? WRITE : READ;
                    cnt_d     = CNT_W'(1);
                    last_wr_d = grant_wr;
                    if (grant_wr == last_wr_q) begin
                        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_W'(1);
                    end else begin
                        burst_d = BURST_W'(1);
                    end
                    if (grant_wr) begin
                        addr_d  = bus.wr_addr;
                        wdata_d = bus.wr_data;
                        we_d    = 1'b1;
                    end else begin
                        addr_d  = bus.rd_addr;
                        re_d    = 1'b1;
                    end
                end else begin
                    burst_d = '0;
                end
            end
            READ, WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    // Last access cycle: drop strobes, capture read data, raise ack for DONE.
                    state_d = DONE;
                    if (state_q == READ) begin
                        rdata_d  = bus.r_data;
                        rd_ack_d = 1'b1;
                    end else begin
                        wr_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    re_d  = (state_q == READ);
                    we_d  = (state_q == WRITE);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            burst_q   <= '0;
            last_wr_q <= 1'b1;   // write counts as served last, so read wins the first tie
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_ack_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            last_wr_q <= last_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            re_q      <= re_d;
            we_q      <= we_d;
            rd_ack_q  <= rd_ack_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    assign bus.address      = addr_q;
    assign bus.w_data       = wdata_q;
    assign bus.rd_data      = rdata_q;
    assign bus.read_enable  = re_q;
    assign bus.write_enable = we_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.wr_ack       = wr_ack_q;
    assign bus.busy         = (state_q != IDLE);

`ifdef SRAM_ARB_STATS_EN
    // Counters step on the same edge that raises the ack, so they already include
    // the access in its DONE cycle.
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (rd_ack_d && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
            if (wr_ack_d && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Testbench for sram_access_arbiter: directed steps plus randomized traffic against a
// transaction-level reference model (grant choice + access timeline arithmetic).
module tb_sram_access_arbiter;
    localparam int AB = 16;
    localparam int DB = 24;
    localparam int AC = 5;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic n_rst;

    sram_access_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    sram_access_arbiter #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .ACCESS_CYCLES(AC), .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus)
`ifdef SRAM_ARB_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;
    int cyc;

    // requester behaviour: 0 = only finish what is pending, 1 = random, 2 = always re-request
    int          rd_mode, wr_mode;
    bit          rd_stream;
    logic [15:0] rd_next;
    bit          rdata_fix_en;
    logic [23:0] rdata_fix;

    int ack_side[$];   // 0 = read, 1 = write
    int ack_cyc[$];

    // reference model
    bit          m_act;
    bit          m_wr;
    int          m_start;
    logic [15:0] m_address;
    logic [23:0] m_wdata;
    logic [23:0] m_rdata;
    bit          m_last_wr;
    int          m_burst;
`ifdef SRAM_ARB_STATS_EN
    int          m_rd_cnt, m_wr_cnt;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act     = 1'b0;
        m_wr      = 1'b0;
        m_start   = 0;
        m_address = '0;
        m_wdata   = '0;
        m_rdata   = '0;
        m_last_wr = 1'b1;
        m_burst   = 0;
`ifdef SRAM_ARB_STATS_EN
        m_rd_cnt  = 0;
        m_wr_cnt  = 0;
`endif
    endtask

    // Tie goes to the side not served last; a side that used its full burst yields
    // to a waiting other side.
    function automatic bit pick_write(input bit r, input bit w);
        bit other_waiting;
        other_waiting = m_last_wr ? r : w;
        if (m_burst >= MB && other_waiting) return !m_last_wr;
        if (r && w) return !m_last_wr;
        return w;
    endfunction

    // Advances the model past the current cycle using this cycle's inputs.
    task automatic model_advance();
        int off;
        bit w;
        if (!n_rst) begin
            model_reset();
            return;
        end
        if (m_act) begin
            off = cyc - m_start;
            if (off == AC) begin
                if (m_wr) begin
`ifdef SRAM_ARB_STATS_EN
                    if (m_wr_cnt < 16'hFFFF) m_wr_cnt++;
`endif
                end else begin
                    m_rdata = bus.r_data;
`ifdef SRAM_ARB_STATS_EN
                    if (m_rd_cnt < 16'hFFFF) m_rd_cnt++;
`endif
                end
            end else if (off == AC + 1) begin
                m_act = 1'b0;
            end
        end else if (bus.rd_req || bus.wr_req) begin
            w         = pick_write(bus.rd_req, bus.wr_req);
            m_burst   = (w == m_last_wr) ? ((m_burst < MB) ? m_burst + 1 : MB) : 1;
            m_last_wr = w;
            m_act     = 1'b1;
            m_wr      = w;
            m_start   = cyc;
            m_address = w ? bus.wr_addr : bus.rd_addr;
            if (w) m_wdata = bus.wr_data;
        end else begin
            m_burst = 0;
        end
    endtask

    task automatic check_outputs();
        int off;
        bit act;
        off = cyc - m_start;
        act = m_act && (off >= 1) && (off <= AC + 1);
        chk("busy",         32'(bus.busy),         32'(act));
        chk("read_enable",  32'(bus.read_enable),  32'(act && !m_wr && off <= AC));
        chk("write_enable", 32'(bus.write_enable), 32'(act && m_wr && off <= AC));
        chk("rd_ack",       32'(bus.rd_ack),       32'(act && !m_wr && off == AC + 1));
        chk("wr_ack",       32'(bus.wr_ack),       32'(act && m_wr && off == AC + 1));
        chk("address",      32'(bus.address),      32'(m_address));
        chk("w_data",       32'(bus.w_data),       32'(m_wdata));
        chk("rd_data",      32'(bus.rd_data),      32'(m_rdata));
`ifdef SRAM_ARB_STATS_EN
        chk("rd_count",     32'(rd_count),         32'(m_rd_cnt));
        chk("wr_count",     32'(wr_count),         32'(m_wr_cnt));
`endif
    endtask

    task automatic new_rd();
        bus.rd_req = 1'b1;
        if (rd_stream) begin
            bus.rd_addr = rd_next;
            rd_next     = rd_next + 16'd1;
        end else begin
            bus.rd_addr = 16'($urandom);
        end
    endtask

    task automatic new_wr();
        bus.wr_req  = 1'b1;
        bus.wr_addr = 16'($urandom);
        bus.wr_data = 24'($urandom);
    endtask

    task automatic drive_requesters(input bit rd_acked, input bit wr_acked);
        if (bus.rd_req) begin
            if (rd_acked) begin
                if (rd_mode == 2 || (rd_mode == 1 && $urandom_range(1) == 1)) new_rd();
                else begin
                    bus.rd_req  = 1'b0;
                    bus.rd_addr = 16'($urandom);
                end
            end
        end else if (rd_mode == 2 || (rd_mode == 1 && $urandom_range(2) == 0)) begin
            new_rd();
        end else begin
            bus.rd_addr = 16'($urandom);
        end

        if (bus.wr_req) begin
            if (wr_acked) begin
                if (wr_mode == 2 || (wr_mode == 1 && $urandom_range(1) == 1)) new_wr();
                else begin
                    bus.wr_req  = 1'b0;
                    bus.wr_data = 24'($urandom);
                end
            end
        end else if (wr_mode == 2 || (wr_mode == 1 && $urandom_range(2) == 0)) begin
            new_wr();
        end else begin
            bus.wr_addr = 16'($urandom);
        end

        bus.r_data = rdata_fix_en ? rdata_fix : 24'($urandom);
    endtask

    // One clock cycle: check at the falling edge, step the model, drive after the rising edge.
    task automatic tick();
        bit ra, wa;
        @(negedge clk);
        check_outputs();
        ra = bus.rd_ack;
        wa = bus.wr_ack;
        if (ra) begin ack_side.push_back(0); ack_cyc.push_back(cyc); end
        if (wa) begin ack_side.push_back(1); ack_cyc.push_back(cyc); end
        model_advance();
        @(posedge clk);
        #1;
        cyc++;
        drive_requesters(ra, wa);
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (ack_side.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(ack_side.size()), 32'(n));
    endtask

    task automatic clear_log();
        ack_side.delete();
        ack_cyc.delete();
    endtask

    task automatic hold_reset(input int n);
        n_rst = 1'b0;
        model_reset();
        repeat (n) tick();
    endtask

    initial begin
        int t0;
        int k;
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        rd_mode = 0;
        wr_mode = 0;
        rd_stream = 1'b0;
        rd_next = '0;
        rdata_fix_en = 1'b0;
        rdata_fix = '0;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.r_data = '0;
        n_rst = 1'b1;
        model_reset();
        #1;

        // Reset held with random inputs: everything must read zero.
        n_rst = 1'b0;
        bus.rd_req  = 1'($urandom);
        bus.wr_req  = 1'($urandom);
        bus.rd_addr = 16'($urandom);
        bus.wr_addr = 16'($urandom);
        bus.wr_data = 24'($urandom);
        repeat (4) tick();

        // Release with both requesting: read first, then write.
        clear_log();
        bus.rd_req  = 1'b1;
        bus.rd_addr = 16'h0100;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 16'h0200;
        bus.wr_data = 24'h123456;
        n_rst = 1'b1;
        wait_acks("tie_acks", 2, 30);
        chk("tie_first_is_read", 32'(ack_side[0]), 32'd0);
        chk("tie_second_is_write", 32'(ack_side[1]), 32'd1);
        chk("tie_ack_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'(AC + 2));
        repeat (2) tick();

        // Single read.
        clear_log();
        rdata_fix_en = 1'b1;
        rdata_fix = 24'hAABBCC;
        bus.r_data = rdata_fix;
        bus.rd_req = 1'b1;
        bus.rd_addr = 16'h0010;
        t0 = cyc;
        wait_acks("single_read_ack", 1, 20);
        chk("single_read_latency", 32'(ack_cyc[0] - t0), 32'(AC + 1));
        chk("single_read_data", 32'(bus.rd_data), 32'hAABBCC);
        chk("single_read_side", 32'(ack_side[0]), 32'd0);
        rdata_fix_en = 1'b0;
        repeat (2) tick();

        // Single write.
        clear_log();
        bus.wr_req = 1'b1;
        bus.wr_addr = 16'h1234;
        bus.wr_data = 24'h00007F;
        t0 = cyc;
        wait_acks("single_write_ack", 1, 20);
        chk("single_write_latency", 32'(ack_cyc[0] - t0), 32'(AC + 1));
        chk("single_write_wdata", 32'(bus.w_data), 32'h00007F);
        chk("single_write_side", 32'(ack_side[0]), 32'd1);
        repeat (2) tick();

        // Contention from reset: both sides request continuously.
        hold_reset(2);
        clear_log();
        rd_mode = 2;
        wr_mode = 2;
        new_rd();
        new_wr();
        n_rst = 1'b1;
        wait_acks("contention_acks", 8, 8 * (AC + 2) + 20);
        for (int i = 0; i < 8; i++) begin
            chk("contention_side", 32'(ack_side[i]), 32'(i % 2));
            if (i > 0) chk("contention_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(AC + 2));
        end
        rd_mode = 0;
        wr_mode = 0;
        repeat (20) tick();

        // Read-only streaming with incrementing addresses.
        clear_log();
        rd_stream = 1'b1;
        rd_next = 16'h0201;
        bus.rd_req = 1'b1;
        bus.rd_addr = 16'h0200;
        rd_mode = 2;
        wait_acks("stream_acks", 10, 10 * (AC + 2) + 20);
        rd_mode = 0;
        for (int i = 0; i < 10; i++) begin
            chk("stream_side", 32'(ack_side[i]), 32'd0);
            if (i > 0) chk("stream_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'(AC + 2));
        end
        rd_stream = 1'b0;
        repeat (12) tick();

        // Randomized traffic on both sides.
        clear_log();
        rd_mode = 1;
        wr_mode = 1;
        repeat (3000) tick();
        rd_mode = 0;
        wr_mode = 0;
        repeat (20) tick();
        chk("random_traffic_active", 32'(ack_side.size() > 100), 32'd1);

        // Reset in the third write cycle.
        clear_log();
        bus.wr_req = 1'b1;
        bus.wr_addr = 16'h0ABC;
        bus.wr_data = 24'h5A5A5A;
        k = 0;
        while (!(m_act && m_wr && (cyc - m_start) == 3) && k < 20) begin
            tick();
            k++;
        end
        chk("midwrite_reached", 32'(m_act && m_wr && (cyc - m_start) == 3), 32'd1);
        chk("midwrite_we_before_reset", 32'(bus.write_enable), 32'd1);
        #2;
        n_rst = 1'b0;
        bus.wr_req = 1'b0;
        #1;
        chk("midwrite_we_cleared", 32'(bus.write_enable), 32'd0);
        chk("midwrite_busy_cleared", 32'(bus.busy), 32'd0);
        chk("midwrite_address_cleared", 32'(bus.address), 32'd0);
        chk("midwrite_wdata_cleared", 32'(bus.w_data), 32'd0);
        chk("midwrite_no_ack", 32'(bus.wr_ack), 32'd0);
        model_reset();
        repeat (2) tick();
        n_rst = 1'b1;
        repeat (12) tick();
        chk("midwrite_no_ack_after", 32'(ack_side.size()), 32'd0);

`ifdef SRAM_ARB_STATS_EN
        chk("stats_wr_count_zero", 32'(wr_count), 32'd0);
        for (int i = 0; i < 2; i++) begin
            clear_log();
            bus.wr_req = 1'b1;
            bus.wr_addr = 16'(16'h0300 + i);
            bus.wr_data = 24'($urandom);
            wait_acks("stats_write_ack", 1, 20);
            tick();
        end
        chk("stats_wr_count_two", 32'(wr_count), 32'd2);
        chk("stats_rd_count_zero", 32'(rd_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
